// File: rtl/result_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : result_wb_buffer
//  Purpose  : Circular FIFO between the ALU result register and the register
//             file / ROB write-back. Squashed results become holes that are
//             discarded at the head. One registered output stage.
//  Revision : 1.0 - initial release
// ============================================================================
module result_wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [91:0]              IN_uop,
  input  logic                     IN_invalidate,
  input  logic [5:0]               IN_invalidateSqN,
  input  logic                     IN_rfReady,
  output logic                     OUT_wbStall,
  output logic                     OUT_rfWe,
  output logic [4:0]               OUT_rfAddr,
  output logic [31:0]              OUT_rfData,
  output logic [5:0]               OUT_rfTag,
  output logic                     OUT_robValid,
  output logic [5:0]               OUT_robSqN,
  output logic [1:0]               OUT_robFlags,
  output logic                     OUT_robBranchTaken,
  output logic [$clog2(DEPTH):0]   OUT_count,
  output logic                     OUT_overflow
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_DEPTH_M1 = c_CW'(DEPTH - 1);

  // Sequence numbers wrap at 64; "younger than the boundary" is a positive
  // signed 6-bit distance.
  function automatic logic isSquashed(input logic inv, input logic [5:0] sqN,
                                      input logic [5:0] bound);
    logic [5:0] diff;
    diff = sqN - bound;
    return inv && (diff != 6'd0) && !diff[5];
  endfunction

  // Incoming uop fields
  logic [31:0] w_uopResult;
  logic [5:0]  w_uopTag;
  logic [4:0]  w_uopRd;
  logic [5:0]  w_uopSqN;
  logic        w_uopTaken;
  logic [1:0]  w_uopFlags;
  logic        w_uopValid;
  logic        w_uopSquashed;
  logic [38:0] w_unused;

  assign w_uopResult   = IN_uop[91:60];
  assign w_uopTag      = IN_uop[59:54];
  assign w_uopRd       = IN_uop[53:49];
  assign w_uopSqN      = IN_uop[48:43];
  assign w_uopTaken    = IN_uop[9];
  assign w_uopFlags    = IN_uop[2:1];
  assign w_uopValid    = IN_uop[0];
  assign w_uopSquashed = isSquashed(IN_invalidate, w_uopSqN, IN_invalidateSqN);
  // pc, isBranch and branchID are not needed after execution
  assign w_unused      = {IN_uop[42:10], IN_uop[8:3]};

  // Slot storage
  logic        r_slotValid  [DEPTH];
  logic [31:0] r_slotResult [DEPTH];
  logic [5:0]  r_slotTag    [DEPTH];
  logic [4:0]  r_slotRd     [DEPTH];
  logic [5:0]  r_slotSqN    [DEPTH];
  logic [1:0]  r_slotFlags  [DEPTH];
  logic        r_slotTaken  [DEPTH];

  logic [c_AW-1:0] r_wrPtr;
  logic [c_AW-1:0] r_rdPtr;
  logic [c_CW-1:0] r_count;
  logic            r_overflow;

  logic [DEPTH-1:0] w_occupied;
  logic [DEPTH-1:0] w_squashSlot;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_slot
      logic [c_AW-1:0] w_off;
      assign w_off           = c_AW'(i) - r_rdPtr;
      assign w_occupied[i]   = ({1'b0, w_off} < r_count);
      assign w_squashSlot[i] = isSquashed(IN_invalidate, r_slotSqN[i], IN_invalidateSqN);
    end
  endgenerate

  // Head / flow control
  logic w_notEmpty, w_full, w_headValid, w_headSquashed;
  logic w_pop, w_validPop, w_enq, w_overflowEvt;

  assign w_notEmpty     = (r_count != '0);
  assign w_full         = (r_count == c_DEPTH);
  assign w_headValid    = r_slotValid[r_rdPtr];
  assign w_headSquashed = isSquashed(IN_invalidate, r_slotSqN[r_rdPtr], IN_invalidateSqN);
  // A hole leaves regardless of the RF port; a live head needs the port and
  // must survive this cycle's flush.
  assign w_pop          = w_notEmpty && (!w_headValid || (!w_headSquashed && IN_rfReady));
  assign w_validPop     = w_pop && w_headValid;
  // A full FIFO can still accept when the head leaves on the same edge.
  assign w_enq          = w_uopValid && (!w_full || w_pop);
  assign w_overflowEvt  = w_uopValid && w_full && !w_pop;

  assign OUT_wbStall  = (r_count >= c_DEPTH_M1);
  assign OUT_count    = r_count;
  assign OUT_overflow = r_overflow;

  // Pointers, occupancy, slot valid bits and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int k = 0; k < DEPTH; k++) r_slotValid[k] <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_occupied[k] && w_squashSlot[k]) r_slotValid[k] <= 1'b0;
      end
      // New entry written last so it wins over a flush of the slot it reuses
      if (w_enq) begin
        r_slotValid[r_wrPtr] <= !w_uopSquashed;
        r_wrPtr              <= r_wrPtr + 1'b1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + c_CW'(w_enq) - c_CW'(w_pop);
      if (w_overflowEvt) r_overflow <= 1'b1;
    end
  end

  // Slot payload; no reset needed since the valid bit qualifies it
  always_ff @(posedge clk) begin
    if (rst && w_enq) begin
      r_slotResult[r_wrPtr] <= w_uopResult;
      r_slotTag[r_wrPtr]    <= w_uopTag;
      r_slotRd[r_wrPtr]     <= w_uopRd;
      r_slotSqN[r_wrPtr]    <= w_uopSqN;
      r_slotFlags[r_wrPtr]  <= w_uopFlags;
      r_slotTaken[r_wrPtr]  <= w_uopTaken;
    end
  end

  // Output stage: strobes for one cycle per live pop, data held otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      OUT_robValid       <= 1'b0;
      OUT_rfWe           <= 1'b0;
      OUT_rfAddr         <= '0;
      OUT_rfData         <= '0;
      OUT_rfTag          <= '0;
      OUT_robSqN         <= '0;
      OUT_robFlags       <= '0;
      OUT_robBranchTaken <= 1'b0;
    end else begin
      OUT_robValid <= w_validPop;
      OUT_rfWe     <= w_validPop && (r_slotRd[r_rdPtr] != 5'd0);
      if (w_validPop) begin
        OUT_rfAddr         <= r_slotRd[r_rdPtr];
        OUT_rfData         <= r_slotResult[r_rdPtr];
        OUT_rfTag          <= r_slotTag[r_rdPtr];
        OUT_robSqN         <= r_slotSqN[r_rdPtr];
        OUT_robFlags       <= r_slotFlags[r_rdPtr];
        OUT_robBranchTaken <= r_slotTaken[r_rdPtr];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_wb_buffer
//  Purpose  : Scoreboard bench for result_wb_buffer against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_wb_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [91:0]   IN_uop = '0;
  logic          IN_invalidate = 1'b0;
  logic [5:0]    IN_invalidateSqN = '0;
  logic          IN_rfReady = 1'b0;
  logic          OUT_wbStall, OUT_rfWe, OUT_robValid, OUT_robBranchTaken, OUT_overflow;
  logic [4:0]    OUT_rfAddr;
  logic [31:0]   OUT_rfData;
  logic [5:0]    OUT_rfTag, OUT_robSqN;
  logic [1:0]    OUT_robFlags;
  logic [CW-1:0] OUT_count;

  result_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .IN_uop(IN_uop), .IN_invalidate(IN_invalidate),
    .IN_invalidateSqN(IN_invalidateSqN), .IN_rfReady(IN_rfReady),
    .OUT_wbStall(OUT_wbStall), .OUT_rfWe(OUT_rfWe), .OUT_rfAddr(OUT_rfAddr),
    .OUT_rfData(OUT_rfData), .OUT_rfTag(OUT_rfTag), .OUT_robValid(OUT_robValid),
    .OUT_robSqN(OUT_robSqN), .OUT_robFlags(OUT_robFlags),
    .OUT_robBranchTaken(OUT_robBranchTaken), .OUT_count(OUT_count),
    .OUT_overflow(OUT_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [31:0] res;
    bit [5:0]  tag;
    bit [4:0]  rd;
    bit [5:0]  sqN;
    bit [1:0]  flags;
    bit        taken;
  } ent_t;

  ent_t mQ[$];    // model buffer contents, oldest first
  ent_t sbQ[$];   // expected completions
  bit   mOverflow = 0;
  bit   mExpValid = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit squashed(bit inv, bit [5:0] x, bit [5:0] b);
    int d;
    d = (int'(x) - int'(b) + 64) % 64;
    return inv && (d > 0) && (d < 32);
  endfunction

  function automatic logic [91:0] mkUop(logic [31:0] res, logic [5:0] sqN, logic [4:0] rd,
                                        logic [5:0] tag, logic [1:0] fl, logic tk);
    logic [91:0] u;
    u        = '0;
    u[91:60] = res;
    u[59:54] = tag;
    u[53:49] = rd;
    u[48:43] = sqN;
    u[42:11] = $urandom;
    u[10]    = 1'($urandom);
    u[9]     = tk;
    u[8:3]   = 6'($urandom);
    u[2:1]   = fl;
    u[0]     = 1'b1;
    return u;
  endfunction

  // Reference model: ordered list of entries, updated once per rising edge
  always @(posedge clk) begin
    ent_t h;
    ent_t e;
    bit   popIt;
    popIt     = 0;
    mExpValid = 0;
    if (!rst) begin
      mQ.delete();
      mOverflow = 0;
    end else begin
      if (mQ.size() > 0) begin
        h = mQ[0];
        if (!h.v) popIt = 1;
        else if (IN_rfReady && !squashed(IN_invalidate, h.sqN, IN_invalidateSqN)) begin
          popIt = 1;
          mExpValid = 1;
          sbQ.push_back(h);
        end
      end
      foreach (mQ[k]) if (squashed(IN_invalidate, mQ[k].sqN, IN_invalidateSqN)) mQ[k].v = 0;
      if (popIt) void'(mQ.pop_front());
      if (IN_uop[0]) begin
        if (mQ.size() < DEPTH) begin
          e.v     = !squashed(IN_invalidate, IN_uop[48:43], IN_invalidateSqN);
          e.res   = IN_uop[91:60];
          e.tag   = IN_uop[59:54];
          e.rd    = IN_uop[53:49];
          e.sqN   = IN_uop[48:43];
          e.flags = IN_uop[2:1];
          e.taken = IN_uop[9];
          mQ.push_back(e);
        end else begin
          mOverflow = 1;
        end
      end
    end
  end

  // Monitor: per-cycle status plus scoreboard pop on every completion
  always @(negedge clk) begin
    ent_t e;
    chk("count", 64'(OUT_count), 64'(mQ.size()));
    chk("overflow", 64'(OUT_overflow), 64'(mOverflow));
    chk("wbStall", 64'(OUT_wbStall), 64'(mQ.size() >= DEPTH - 1));
    chk("robValid", 64'(OUT_robValid), 64'(mExpValid));
    if (OUT_robValid === 1'b1) begin
      if (sbQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_completion: got sqN 0x%0h expected none at %0t", OUT_robSqN, $time);
      end else begin
        e = sbQ.pop_front();
        chk("robSqN", 64'(OUT_robSqN), 64'(e.sqN));
        chk("rfWe", 64'(OUT_rfWe), 64'(e.rd != 0));
        chk("rfAddr", 64'(OUT_rfAddr), 64'(e.rd));
        chk("rfData", 64'(OUT_rfData), 64'(e.res));
        chk("rfTag", 64'(OUT_rfTag), 64'(e.tag));
        chk("robFlags", 64'(OUT_robFlags), 64'(e.flags));
        chk("robBranchTaken", 64'(OUT_robBranchTaken), 64'(e.taken));
      end
    end else begin
      chk("rfWe_idle", 64'(OUT_rfWe), 64'd0);
    end
  end

  task automatic drive(input logic [91:0] u, input logic inv, input logic [5:0] isq,
                       input logic rdy, input logic r);
    @(negedge clk);
    #1;
    IN_uop = u; IN_invalidate = inv; IN_invalidateSqN = isq; IN_rfReady = rdy; rst = r;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) drive('0, 1'b0, 6'd0, rdy, 1'b1);
  endtask

  initial begin
    int n;
    int seq;

    // Reset and reset-state outputs
    drive('0, 0, 0, 1, 0);
    drive('0, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk("rst_rfAddr", 64'(OUT_rfAddr), 0);
    chk("rst_rfData", 64'(OUT_rfData), 0);
    chk("rst_rfTag", 64'(OUT_rfTag), 0);
    chk("rst_robSqN", 64'(OUT_robSqN), 0);
    chk("rst_robFlags", 64'(OUT_robFlags), 0);
    chk("rst_robBranchTaken", 64'(OUT_robBranchTaken), 0);
    idle(2, 1);

    // Single uop, two-edge latency
    drive(mkUop(32'hDEADBEEF, 6'd3, 5'd5, 6'd11, 2'd0, 1'b0), 0, 0, 1, 1);
    idle(4, 1);

    // Fill while the stall is low, one in-flight uop, then an overflowing one
    idle(1, 0);
    for (n = 0; n < 8; n++) begin
      @(negedge clk); #1;
      if (OUT_wbStall === 1'b1) break;
      IN_uop = mkUop($urandom, 6'(10 + n), 5'(n + 1), 6'(n), 2'd1, 1'b1);
    end
    chk("fill_issued", 64'(n), 64'(DEPTH - 1));
    IN_uop = mkUop(32'h1111_2222, 6'd20, 5'd7, 6'd7, 2'd2, 1'b0);
    @(posedge clk); #1;
    chk("fill_count", 64'(OUT_count), 64'(DEPTH));
    chk("fill_no_overflow", 64'(OUT_overflow), 0);
    drive(mkUop(32'h3333_4444, 6'd21, 5'd8, 6'd8, 2'd3, 1'b1), 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("ovf_flag", 64'(OUT_overflow), 1);
    chk("ovf_count", 64'(OUT_count), 64'(DEPTH));
    idle(8, 1);
    drive('0, 0, 0, 1, 0);
    idle(1, 1);

    // Flush: boundary 2 keeps sqN 1 and 2
    drive(mkUop(32'hA1, 6'd1, 5'd1, 6'd1, 2'd0, 1'b0), 0, 0, 0, 1);
    drive(mkUop(32'hA2, 6'd2, 5'd2, 6'd2, 2'd1, 1'b1), 0, 0, 0, 1);
    drive(mkUop(32'hA6, 6'd6, 5'd3, 6'd3, 2'd2, 1'b0), 0, 0, 0, 1);
    drive(mkUop(32'hA7, 6'd7, 5'd4, 6'd4, 2'd3, 1'b1), 0, 0, 0, 1);
    drive('0, 1, 6'd2, 0, 1);
    idle(6, 1);

    // Wrap-around squash: boundary 62 kills 63 and 1, keeps 61
    drive(mkUop(32'hB61, 6'd61, 5'd9, 6'd5, 2'd0, 1'b0), 0, 0, 0, 1);
    drive(mkUop(32'hB63, 6'd63, 5'd10, 6'd6, 2'd1, 1'b0), 0, 0, 0, 1);
    drive(mkUop(32'hB01, 6'd1, 5'd11, 6'd7, 2'd2, 1'b1), 0, 0, 0, 1);
    drive('0, 1, 6'd62, 0, 1);
    idle(6, 1);

    // rd = 0 completes without a register write
    drive(mkUop(32'hC0FFEE, 6'd9, 5'd0, 6'd9, 2'd1, 1'b0), 0, 0, 1, 1);
    idle(4, 1);

    // Reset with three buffered entries
    drive(mkUop(32'hD1, 6'd30, 5'd1, 6'd1, 2'd0, 1'b0), 0, 0, 0, 1);
    drive(mkUop(32'hD2, 6'd31, 5'd2, 6'd2, 2'd0, 1'b0), 0, 0, 0, 1);
    drive(mkUop(32'hD3, 6'd32, 5'd3, 6'd3, 2'd0, 1'b0), 0, 0, 0, 1);
    drive(mkUop(32'hD4, 6'd33, 5'd4, 6'd4, 2'd0, 1'b0), 0, 0, 1, 0);
    @(posedge clk); #1;
    chk("midrst_count", 64'(OUT_count), 0);
    chk("midrst_stall", 64'(OUT_wbStall), 0);
    idle(4, 1);

    // Randomized traffic
    seq = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      rst              = ($urandom_range(0, 199) != 0);
      IN_rfReady       = ($urandom_range(0, 9) < 7);
      IN_invalidate    = ($urandom_range(0, 9) == 0);
      IN_invalidateSqN = 6'(seq - int'($urandom_range(0, 6)));
      if ((OUT_wbStall !== 1'b1 && $urandom_range(0, 9) < 6) || $urandom_range(0, 49) == 0) begin
        IN_uop = mkUop($urandom, 6'(seq), 5'($urandom_range(0, 31)), 6'($urandom),
                       2'($urandom), 1'($urandom));
        seq++;
      end else begin
        IN_uop = '0;
      end
    end
    idle(10, 1);
    chk("scoreboard_drained", 64'(sbQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_wb_buffer.md
RESULT_WB_BUFFER -- requirements
Module: result_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries; legal values are powers of two, at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port IN_uop, input, 92 bits: result uop from the ALU.
- [91:60] result
- [59:54] tag
- [53:49] rd
- [48:43] sqN
- [42:11] pc
- [10] isBranch
- [9] branchTaken
- [8:3] branchID
- [2:1] flags
- [0] valid
REQ-005 SHALL have port IN_invalidate, input, 1 bit: flush request.
REQ-006 SHALL have port IN_invalidateSqN, input, 6 bits: the oldest squashed-boundary sqN.
REQ-007 SHALL have port IN_rfReady, input, 1 bit: the register-file write port accepts a write this cycle.
REQ-008 SHALL have port OUT_wbStall, output, 1 bit: the producer must not issue.
REQ-009 SHALL have ports OUT_rfWe (1), OUT_rfAddr (5), OUT_rfData (32) and OUT_rfTag (6), all outputs: the register-file write.
REQ-010 SHALL have ports OUT_robValid (1), OUT_robSqN (6), OUT_robFlags (2) and OUT_robBranchTaken (1), all outputs: the ROB completion.
REQ-011 SHALL have port OUT_count, output, $clog2(DEPTH)+1 bits: the number of occupied slots.
REQ-012 SHALL have port OUT_overflow, output, 1 bit: sticky error flag.

Function
REQ-013 SHALL implement a circular FIFO of DEPTH slots, each holding a valid bit plus result, tag, rd, sqN, flags and branchTaken; pc and branchID are dropped.
- rd = 0 is legal: the entry completes to the ROB with OUT_rfWe=0.
REQ-014 SHALL define "squashed(x)" as IN_invalidate && $signed(x - IN_invalidateSqN) > 0, using 6-bit wrap-around subtraction.
REQ-015 SHALL enqueue IN_uop when IN_uop[0]=1, writing slot[wrPtr] and advancing wrPtr modulo DEPTH.
- The entry is stored with valid = !squashed(IN_uop sqN).
- A squashed incoming uop still consumes a slot, as a hole.
REQ-016 SHALL, each cycle IN_invalidate=1, clear the valid bit of every occupied slot whose sqN is squashed; slot order and pointers are unchanged.
REQ-017 SHALL treat the head as "poppable" when count>0 and any of the following holds:
- the head valid bit is 0, in which case it is discarded regardless of IN_rfReady;
- the head is valid, not squashed this cycle, and IN_rfReady=1.
REQ-018 SHALL pop at most one slot per cycle; a valid popped head is registered into the output stage on that edge.
REQ-019 SHALL hold output-stage values for exactly one cycle after a valid pop.
- OUT_robValid = 1.
- OUT_rfWe = (rd != 0).
- Otherwise OUT_robValid and OUT_rfWe are 0, and the data outputs hold their last value.
REQ-020 SHALL produce latency of 2 edges from IN_uop valid to OUT_robValid when the FIFO is empty and IN_rfReady=1; there is no bypass path.
REQ-021 SHALL update count = count + enq - pop on the same edge; a simultaneous enqueue and pop with count = DEPTH is legal and leaves count unchanged.
REQ-022 SHALL drive OUT_wbStall combinationally as count >= DEPTH-1, which leaves one slot for the uop already in flight in the ALU output register.
REQ-023 SHALL, on enqueue when count = DEPTH with no pop:
- drop the uop;
- set OUT_overflow=1 until reset;
- leave FIFO contents unchanged.
REQ-024 SHALL never allow a head squashed in the same cycle as its pop to produce OUT_robValid or OUT_rfWe.

Reset
REQ-025 SHALL, while rst=0 at a rising edge, clear the following:
- wrPtr, rdPtr, count and all slot valid bits;
- OUT_rfWe, OUT_robValid and OUT_overflow;
- OUT_rfAddr, OUT_rfData, OUT_rfTag, OUT_robSqN, OUT_robFlags and OUT_robBranchTaken, all set to 0.
REQ-026 SHALL, when reset is asserted mid-operation, discard in-flight and buffered entries, ignore inputs in that cycle, and produce no output the following cycle.

Verification
REQ-027 Single uop: IN_uop valid with rd=5, result=0xDEADBEEF, sqN=3, flags=0; IN_rfReady=1; empty FIFO -> exactly 2 edges later OUT_rfWe=1, OUT_rfAddr=5, OUT_rfData=0xDEADBEEF, OUT_robSqN=3, for one cycle.
REQ-028 Fill: IN_rfReady=0 with one uop per cycle while OUT_wbStall=0, then one in-flight uop -> count=4, OUT_wbStall=1 from count 3 onward, OUT_overflow=0; then a fifth uop -> OUT_overflow=1 and count stays 4.
REQ-029 Flush: entries sqN 1, 2, 6, 7 buffered; IN_invalidate=1 with IN_invalidateSqN=2; then IN_rfReady=1 -> only sqN 1 and 2 appear on OUT_robValid, on consecutive cycles, and count reaches 0 within 4 cycles.
REQ-030 Wrap: IN_invalidateSqN=62 with buffered sqN 63 and 1 -> both squashed; buffered sqN 61 is retained.
REQ-031 rd=0: uop with rd=0 and sqN=9 -> OUT_robValid=1, OUT_robSqN=9, OUT_rfWe=0.
REQ-032 Reset mid-run: 3 buffered entries, rst=0 for one cycle -> count=0, OUT_wbStall=0, and no OUT_robValid afterwards.
